wb_trace_buffer: RTL and testbench

//  Parametrised hardware writeback-trace unit; successor to the ad-hoc probing of regfile/pipeline latches.
//  - Sits beside the processor and taps the writeback port (ctrl_writeEnable/ctrl_writeReg/data_writeReg).
//  - Records each committed register write with a cycle stamp into an on-chip FIFO, with arm/trigger/freeze control.
//  - Read out through a valid/ready-style pop port.

---
 rtl/wb_trace_pkg.sv | 22 ++
 rtl/trace_fifo_ram.sv | 36 +++
 rtl/wb_trace_buffer.sv | 128 ++++++++++++
 tb/tb_wb_trace_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace unit: FSM encodings, entry field offsets, drop counter width.
// Entry layout, MSB to LSB: {stamp, reg, data}.
package wb_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } trace_state_e;

    localparam int DROPS_WIDTH = 16;
    localparam int DATA_LSB    = 0;

    function automatic int reg_lsb(input int data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int stamp_lsb(input int data_w, input int reg_w);
        return reg_lsb(data_w) + reg_w;
    endfunction

endpackage

// File: rtl/trace_fifo_ram.sv
// DEPTH x WIDTH trace storage, one write port and a registered read port (data 1 cycle after rd_en_i).
// No backpressure: the owner guarantees address legality. Read of the slot being written returns old data.
module trace_fifo_ram #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace: stamps committed register writes into a FIFO with arm/trigger/freeze; pop data 1 cycle after rd_en_i.
// Full FIFO drops the new entry, or overwrites the oldest when WB_TRACE_WRAP_EN is defined; drops counted either way.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 16,
    parameter int CYCLE_WIDTH    = 16
) (
    input  logic                                           clock_i,
    input  logic                                           reset_i,
    input  logic                                           wb_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]                      wb_reg_i,
    input  logic [DATA_WIDTH-1:0]                          wb_data_i,
    input  logic                                           arm_i,
    input  logic                                           trig_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]                      trig_reg_i,
    input  logic [DATA_WIDTH-1:0]                          trig_data_i,
    input  logic                                           rd_en_i,
    output logic                                           rd_valid_o,
    output logic [CYCLE_WIDTH+REG_ADDR_WIDTH+DATA_WIDTH-1:0] rd_entry_o,
    output logic [$clog2(DEPTH):0]                         count_o,
    output logic                                           empty_o,
    output logic                                           full_o,
    output logic [1:0]                                     state_o,
    output logic [DROPS_WIDTH-1:0]                         drops_o
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CNTW    = PW + 1;
    localparam int ENTRY_W = stamp_lsb(DATA_WIDTH, REG_ADDR_WIDTH) + CYCLE_WIDTH;

    trace_state_e            state_q;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]         count_q, count_d;
    logic [CYCLE_WIDTH-1:0]  stamp_q, stamp_d;
    logic [DROPS_WIDTH-1:0]  drops_q, drops_d;
    logic                    rd_valid_q;
    logic                    empty, full, capture, do_pop, do_write, overwrite, lost, trig_hit;
    logic [ENTRY_W-1:0]      wr_entry;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNTW'(DEPTH));
    // arm discards anything happening in the same cycle, capture and pop alike
    assign capture  = wb_en_i && (wb_reg_i != '0) && (state_q == ST_RUN) && !arm_i;
    assign do_pop   = rd_en_i && !empty && !arm_i;
    assign lost     = capture && full && !do_pop;
    assign trig_hit = capture && trig_en_i && (wb_reg_i == trig_reg_i) && (wb_data_i == trig_data_i);
    assign wr_entry = {stamp_q, wb_reg_i, wb_data_i};

`ifdef WB_TRACE_WRAP_EN
    assign do_write  = capture;
    assign overwrite = lost;
`else
    assign do_write  = capture && !lost;
    assign overwrite = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stamp_d  = stamp_q;
        drops_d  = drops_q;
        if (arm_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            stamp_d  = '0;
            drops_d  = '0;
        end else begin
            if (state_q == ST_RUN) stamp_d = stamp_q + CYCLE_WIDTH'(1);
            if (do_write) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop || overwrite) rd_ptr_d = rd_ptr_q + PW'(1);
            // an overwrite retires the oldest entry, so occupancy is unchanged
            if (do_write && !overwrite && !do_pop) count_d = count_q + CNTW'(1);
            else if (do_pop && !do_write) count_d = count_q - CNTW'(1);
            if (lost && (drops_q != '1)) drops_d = drops_q + DROPS_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
            drops_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stamp_q    <= stamp_d;
            drops_q    <= drops_d;
            rd_valid_q <= do_pop;
            if (arm_i) begin
                state_q <= ST_RUN;
            end else if (trig_hit) begin
                state_q <= ST_FROZEN;
            end
        end
    end

    trace_fifo_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_en_i   (do_write),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_en_i   (do_pop),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry_o)
    );

    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;
    assign empty_o    = empty;
    assign full_o     = full;
    assign state_o    = state_q;
    assign drops_o    = drops_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a queue model of the FIFO checked every cycle.
module tb_wb_trace_buffer;

    localparam int DW      = 32;
    localparam int RW      = 5;
    localparam int DEPTH   = 16;
    localparam int CW      = 16;
    localparam int ENTRY_W = CW + RW + DW;
`ifdef WB_TRACE_WRAP_EN
    localparam int FIRST_AFTER_OVF = 3;
`else
    localparam int FIRST_AFTER_OVF = 1;
`endif

    logic               clk = 1'b0;
    logic               reset_i = 1'b1;
    logic               wb_en_i = 1'b0;
    logic [RW-1:0]      wb_reg_i = '0;
    logic [DW-1:0]      wb_data_i = '0;
    logic               arm_i = 1'b0;
    logic               trig_en_i = 1'b0;
    logic [RW-1:0]      trig_reg_i = '0;
    logic [DW-1:0]      trig_data_i = '0;
    logic               rd_en_i = 1'b0;
    logic               rd_valid_o;
    logic [ENTRY_W-1:0] rd_entry_o;
    logic [$clog2(DEPTH):0] count_o;
    logic               empty_o, full_o;
    logic [1:0]         state_o;
    logic [15:0]        drops_o;

    int errors = 0;
    int checks = 0;

    logic [ENTRY_W-1:0] mq[$];
    int                 m_state = 0;
    logic [CW-1:0]      m_stamp = '0;
    logic [15:0]        m_drops = '0;

    always #5 clk = ~clk;

    wb_trace_buffer #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .DEPTH(DEPTH), .CYCLE_WIDTH(CW)
    ) dut (
        .clock_i(clk), .reset_i(reset_i), .wb_en_i(wb_en_i), .wb_reg_i(wb_reg_i),
        .wb_data_i(wb_data_i), .arm_i(arm_i), .trig_en_i(trig_en_i), .trig_reg_i(trig_reg_i),
        .trig_data_i(trig_data_i), .rd_en_i(rd_en_i), .rd_valid_o(rd_valid_o),
        .rd_entry_o(rd_entry_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
        .state_o(state_o), .drops_o(drops_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the inputs currently driven to the model, clock once, then compare.
    task automatic tick();
        logic [ENTRY_W-1:0] exp_e, dummy;
        bit pop_now, cap_now;
        int st0;
        exp_e = '0;
        pop_now = 0;
        cap_now = 0;
        st0 = m_state;
        if (reset_i) begin
            mq.delete();
            m_state = 0;
            m_stamp = '0;
            m_drops = '0;
        end else begin
            pop_now = rd_en_i && (mq.size() > 0) && !arm_i;
            cap_now = wb_en_i && (wb_reg_i != '0) && (m_state == 1) && !arm_i;
            if (pop_now) exp_e = mq.pop_front();
            if (arm_i) begin
                mq.delete();
                m_state = 1;
                m_stamp = '0;
                m_drops = '0;
            end else begin
                if (cap_now) begin
                    if (mq.size() == DEPTH) begin
                        if (m_drops != 16'hFFFF) m_drops++;
`ifdef WB_TRACE_WRAP_EN
                        dummy = mq.pop_front();
                        mq.push_back({m_stamp, wb_reg_i, wb_data_i});
`endif
                    end else begin
                        mq.push_back({m_stamp, wb_reg_i, wb_data_i});
                    end
                    if (trig_en_i && wb_reg_i == trig_reg_i && wb_data_i == trig_data_i) m_state = 2;
                end
                if (st0 == 1) m_stamp++;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid_o, pop_now);
        if (pop_now) chk("rd_entry", rd_entry_o, exp_e);
        chk("count", count_o, mq.size());
        chk("state", state_o, m_state);
        chk("drops", drops_o, m_drops);
        chk("empty", empty_o, mq.size() == 0);
        chk("full", full_o, mq.size() == DEPTH);
    endtask

    task automatic wr(input logic [RW-1:0] r, input logic [DW-1:0] d);
        wb_en_i = 1'b1; wb_reg_i = r; wb_data_i = d;
        tick();
        wb_en_i = 1'b0;
    endtask

    task automatic pop_one();
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
    endtask

    task automatic arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        reset_i = 1'b0;
        chk("reset_entry", rd_entry_o, 0);
        chk("reset_state", state_o, 0);

        // basic capture with cycle stamps 2 and 3
        arm();
        tick();
        tick();
        wr(5'd1, 32'd5);
        wr(5'd2, 32'd7);
        pop_one();
        chk("pop_first", rd_entry_o, {16'd2, 5'd1, 32'd5});
        pop_one();
        chk("pop_second", rd_entry_o, {16'd3, 5'd2, 32'd7});
        tick();
        chk("drained_empty", empty_o, 1);

        // r0 writes are never recorded; pops on empty are ignored
        wr(5'd0, 32'd9);
        chk("r0_count", count_o, 0);
        rd_en_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_en_i = 1'b0;

        // trigger freezes capture; the trigger entry itself is kept
        trig_en_i = 1'b1; trig_reg_i = 5'd3; trig_data_i = 32'hAA;
        wr(5'd3, 32'h55);
        wr(5'd3, 32'hAA);
        wr(5'd4, 32'd1);
        chk("trig_state", state_o, 2);
        chk("trig_count", count_o, 2);
        trig_en_i = 1'b0;
        pop_one();
        pop_one();
        chk("trig_entry_data", rd_entry_o[DW-1:0], 32'hAA);
        chk("trig_entry_reg", rd_entry_o[DW+RW-1:DW], 3);
        tick();
        chk("r4_absent", empty_o, 1);

        // overflow: 18 captures into 16 slots
        arm();
        for (int i = 1; i <= 18; i++) wr(RW'(i), DW'(i));
        chk("ovf_count", count_o, 16);
        chk("ovf_drops", drops_o, 2);
        pop_one();
        chk("ovf_first_pop", rd_entry_o[DW-1:0], FIRST_AFTER_OVF);

        // full FIFO: capture and pop in the same cycle
        arm();
        for (int i = 0; i < 16; i++) wr(RW'(i + 1), DW'(101 + i));
        chk("full_flag", full_o, 1);
        rd_en_i = 1'b1;
        wr(5'd17, 32'd117);
        rd_en_i = 1'b0;
        chk("both_popped_oldest", rd_entry_o[DW-1:0], 101);
        chk("both_count", count_o, 16);
        chk("both_drops", drops_o, 0);
        for (int i = 0; i < 16; i++) pop_one();
        chk("newest_last", rd_entry_o[DW-1:0], 117);

        // reset mid-run with a pop pending
        arm();
        for (int i = 0; i < 5; i++) wr(RW'(i + 1), DW'(200 + i));
        chk("pre_reset_count", count_o, 5);
        reset_i = 1'b1;
        rd_en_i = 1'b1;
        tick();
        reset_i = 1'b0;
        rd_en_i = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
